// File: rtl/spi_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | spi_pkg : shared widths, defaults and FSM encoding for the SPI slave    |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
package spi_pkg;

  localparam int SPI_BYTE_W = 8;
  localparam int SPI_CNT_W  = 3;

  localparam logic [SPI_BYTE_W-1:0] SPI_FILL_DEFAULT = 8'h00;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } spi_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_slave_sync_sync_edge.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | sync_edge : multi-flop input synchronizer with optional edge detection  |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module sync_edge #(
  parameter int SYNC_STAGES = 2,
  parameter bit EDGE_EN     = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] r_sync;

  // Reset to 0 so a pad already low at reset release never looks like a fall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_d};
    end
  end

  assign o_level = r_sync[SYNC_STAGES-1];

  generate
    if (EDGE_EN) begin : g_edge
      logic r_prev;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= o_level;
        end
      end

      assign o_rise = o_level & ~r_prev;
      assign o_fall = ~o_level & r_prev;
    end else begin : g_level
      assign o_rise = 1'b0;
      assign o_fall = 1'b0;
    end
  endgenerate

endmodule : sync_edge
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`timescale 1ns/1ps
`default_nettype none
// +-------------------------------------------------------------------------+
// | spi_slave_sync : oversampled SPI mode-0 slave, byte RX/TX in clk domain |
// | Rev 1.0                                                                 |
// +-------------------------------------------------------------------------+
module spi_slave_sync
  import spi_pkg::*;
#(
  parameter int                     SYNC_STAGES = 2,
  parameter logic [SPI_BYTE_W-1:0]  FILL_BYTE   = SPI_FILL_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sck,
  input  logic                  ss_n,
  input  logic                  mosi,
  output logic                  miso,
  output logic [SPI_BYTE_W-1:0] rx_data,
  output logic                  rx_valid,
  input  logic [SPI_BYTE_W-1:0] tx_data,
  input  logic                  tx_load,
  output logic                  tx_pending,
  output logic                  frame_active,
  output logic                  frame_err
);

  localparam logic [SPI_CNT_W-1:0] c_cnt_last = '1;
  localparam logic [SPI_CNT_W-1:0] c_cnt_one  = {{(SPI_CNT_W-1){1'b0}}, 1'b1};

  logic w_sck_level_unused;
  logic w_sck_rise;
  logic w_sck_fall;
  logic w_ss_level_unused;
  logic w_ss_rise;
  logic w_ss_fall;
  logic w_mosi;
  logic w_mosi_rise_unused;
  logic w_mosi_fall_unused;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_sck (
    .clk     (clk),
    .rst     (rst),
    .i_d     (sck),
    .o_level (w_sck_level_unused),
    .o_rise  (w_sck_rise),
    .o_fall  (w_sck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b1)) u_sync_ss (
    .clk     (clk),
    .rst     (rst),
    .i_d     (ss_n),
    .o_level (w_ss_level_unused),
    .o_rise  (w_ss_rise),
    .o_fall  (w_ss_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .EDGE_EN(1'b0)) u_sync_mosi (
    .clk     (clk),
    .rst     (rst),
    .i_d     (mosi),
    .o_level (w_mosi),
    .o_rise  (w_mosi_rise_unused),
    .o_fall  (w_mosi_fall_unused)
  );

  spi_state_t             r_state;
  spi_state_t             w_state_next;
  logic                   w_active;
  logic                   w_miso;

  logic [SPI_CNT_W-1:0]   r_bit_cnt;
  logic [SPI_BYTE_W-1:0]  r_rx_shift;
  logic [SPI_BYTE_W-1:0]  r_tx_shift;
  logic [SPI_BYTE_W-1:0]  r_tx_hold;
  logic [SPI_BYTE_W-1:0]  r_rx_data;
  logic                   r_tx_pending;
  logic                   r_rx_valid;
  logic                   r_frame_err;

  logic                   w_start;
  logic                   w_stop;
  logic                   w_shift_rx;
  logic                   w_shift_tx;
  logic                   w_boundary;
  logic                   w_consume;
  logic [SPI_BYTE_W-1:0]  w_tx_next;
  logic [SPI_BYTE_W-1:0]  w_rx_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_active     = 1'b0;
    w_miso       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ss_fall) begin
          w_state_next = ACTIVE;
        end
      end
      ACTIVE: begin
        w_active = 1'b1;
        w_miso   = r_tx_shift[SPI_BYTE_W-1];
        if (w_ss_rise) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // SCK edges landing on the same clk as SS deassertion are deliberately dropped.
  assign w_start    = (r_state == IDLE) && w_ss_fall;
  assign w_stop     = w_active && w_ss_rise;
  assign w_shift_rx = w_active && !w_ss_rise && w_sck_rise;
  assign w_shift_tx = w_active && !w_ss_rise && w_sck_fall;
  assign w_boundary = w_shift_tx && (r_bit_cnt == '0);
  assign w_consume  = w_start || w_boundary;
  assign w_tx_next  = r_tx_pending ? r_tx_hold : FILL_BYTE;
  assign w_rx_next  = {r_rx_shift[SPI_BYTE_W-2:0], w_mosi};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_rx_shift  <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_start) begin
        r_bit_cnt <= '0;
      end else if (w_stop) begin
        r_bit_cnt   <= '0;
        r_frame_err <= (r_bit_cnt != '0);
      end else if (w_shift_rx) begin
        r_rx_shift <= w_rx_next;
        r_bit_cnt  <= r_bit_cnt + c_cnt_one;
        if (r_bit_cnt == c_cnt_last) begin
          r_rx_data  <= w_rx_next;
          r_rx_valid <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_shift <= '0;
    end else if (w_consume) begin
      r_tx_shift <= w_tx_next;
    end else if (w_shift_tx) begin
      r_tx_shift <= {r_tx_shift[SPI_BYTE_W-2:0], 1'b0};
    end
  end

  // A load coinciding with a consume wins the pending flag; the consume used the old content.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tx_hold    <= '0;
      r_tx_pending <= 1'b0;
    end else if (tx_load) begin
      r_tx_hold    <= tx_data;
      r_tx_pending <= 1'b1;
    end else if (w_consume) begin
      r_tx_pending <= 1'b0;
    end
  end

  assign miso         = w_miso;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign tx_pending   = r_tx_pending;
  assign frame_active = w_active;
  assign frame_err    = r_frame_err;

endmodule : spi_slave_sync
`default_nettype wire
